// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed bus cycle controller.
// Strobe vectors are ordered {CSO, WRO, RDO, ADO}, all active low.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    A_SETUP  = 4'd1,
    A_STROBE = 4'd2,
    A_HOLD   = 4'd3,
    GAP      = 4'd4,
    D_SETUP  = 4'd5,
    D_STROBE = 4'd6,
    D_HOLD   = 4'd7,
    DONE     = 4'd8
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [3:0] STB_IDLE  = 4'b1111;
  localparam logic [3:0] STB_A     = 4'b0110;
  localparam logic [3:0] STB_A_WR  = 4'b0010;
  localparam logic [3:0] STB_D     = 4'b0111;
  localparam logic [3:0] STB_D_WR  = 4'b0011;
  localparam logic [3:0] STB_D_RD  = 4'b0101;

endpackage

// File: rtl/rtc_phase_timer.sv
// Per-state cycle counter for the RTC bus controller.
// Flags the final cycle of a sub-phase; cleared on every state entry.
module rtc_phase_timer #(
  parameter int T_PHASE = 10,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(T_PHASE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/rtc_bus_cycle_ctrl.sv
// One RTC register access on the muxed address/data bus.
// Outputs are decoded from the next state and registered, so strobes are glitch-free.
module rtc_bus_cycle_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE = 10,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] bus_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       CSO,
  output logic       WRO,
  output logic       RDO,
  output logic       ADO
);

  state_t st, st_nxt;

  logic       tc;
  logic       clr;
  logic       accept;
  logic       rw_q, rw_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] wdata_q, wdata_n;

  logic [3:0] stb_n;
  logic       oe_n;
  logic [7:0] out_n;
  logic       busy_n;
  logic       done_n;

  assign accept = (st == IDLE) && start;
  assign clr    = (st_nxt != st) || (st == IDLE);

  // Outputs for A_SETUP are decoded on the accepting edge, before the latches load.
  assign rw_n    = accept ? rw    : rw_q;
  assign addr_n  = accept ? addr  : addr_q;
  assign wdata_n = accept ? wdata : wdata_q;

  rtc_phase_timer #(
    .T_PHASE (T_PHASE),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:     if (start) st_nxt = A_SETUP;
      A_SETUP:  if (tc) st_nxt = A_STROBE;
      A_STROBE: if (tc) st_nxt = A_HOLD;
      A_HOLD:   if (tc) st_nxt = GAP;
      GAP:      if (tc) st_nxt = D_SETUP;
      D_SETUP:  if (tc) st_nxt = D_STROBE;
      D_STROBE: if (tc) st_nxt = D_HOLD;
      D_HOLD:   if (tc) st_nxt = DONE;
      DONE:     st_nxt = IDLE;
      default:  st_nxt = IDLE;
    endcase
  end

  always_comb begin
    stb_n  = STB_IDLE;
    oe_n   = 1'b0;
    out_n  = 8'h00;
    busy_n = 1'b1;
    done_n = 1'b0;
    unique case (st_nxt)
      IDLE: busy_n = 1'b0;
      A_SETUP, A_HOLD: begin
        stb_n = STB_A;
        oe_n  = 1'b1;
        out_n = addr_n;
      end
      A_STROBE: begin
        stb_n = STB_A_WR;
        oe_n  = 1'b1;
        out_n = addr_n;
      end
      GAP: stb_n = STB_IDLE;
      D_SETUP, D_HOLD: begin
        stb_n = STB_D;
        oe_n  = (rw_n == RW_WRITE);
        out_n = (rw_n == RW_WRITE) ? wdata_n : 8'h00;
      end
      D_STROBE: begin
        stb_n = (rw_n == RW_WRITE) ? STB_D_WR : STB_D_RD;
        oe_n  = (rw_n == RW_WRITE);
        out_n = (rw_n == RW_WRITE) ? wdata_n : 8'h00;
      end
      DONE: begin
        busy_n = 1'b0;
        done_n = 1'b1;
      end
      default: busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_q    <= RW_READ;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else if (accept) begin
      rw_q    <= rw;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {CSO, WRO, RDO, ADO} <= STB_IDLE;
      bus_oe  <= 1'b0;
      bus_out <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      {CSO, WRO, RDO, ADO} <= stb_n;
      bus_oe  <= oe_n;
      bus_out <= out_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Sample on the last strobe cycle while RDO is still low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= 8'h00;
    end else if (st == D_STROBE && tc && rw_q == RW_READ) begin
      rdata <= bus_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_cycle_ctrl.sv
// Directed bench for rtc_bus_cycle_ctrl at T_PHASE=4 and T_PHASE=1.
// Expected per-cycle outputs come from a cycle-index table of the bus sequence.
module tb_rtc_bus_cycle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       start, rw;
  logic [7:0] addr, wdata, bus_in;
  logic       busy, done, bus_oe, CSO, WRO, RDO, ADO;
  logic [7:0] rdata, bus_out;

  logic       start1, rw1;
  logic [7:0] addr1, wdata1, bus_in1;
  logic       busy1, done1, bus_oe1, CSO1, WRO1, RDO1, ADO1;
  logic [7:0] rdata1, bus_out1;

  int total = 0;
  int bad = 0;

  assign bus_in  = (RDO == 1'b0) ? 8'h37 : 8'h00;
  assign bus_in1 = 8'h00;

  rtc_bus_cycle_ctrl #(.T_PHASE(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw),
    .addr(addr), .wdata(wdata), .bus_in(bus_in),
    .busy(busy), .done(done), .rdata(rdata),
    .bus_out(bus_out), .bus_oe(bus_oe),
    .CSO(CSO), .WRO(WRO), .RDO(RDO), .ADO(ADO)
  );

  rtc_bus_cycle_ctrl #(.T_PHASE(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rw(rw1),
    .addr(addr1), .wdata(wdata1), .bus_in(bus_in1),
    .busy(busy1), .done(done1), .rdata(rdata1),
    .bus_out(bus_out1), .bus_oe(bus_oe1),
    .CSO(CSO1), .WRO(WRO1), .RDO(RDO1), .ADO(ADO1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // {CSO,WRO,RDO,ADO,bus_oe,busy,done,bus_out} k cycles after acceptance
  function automatic logic [14:0] exp_vec(input int k, input int t,
                                          input bit w, input logic [7:0] a,
                                          input logic [7:0] d);
    logic [3:0] s;
    logic oe, bz, dn;
    logic [7:0] o;
    s = 4'hF; oe = 1'b0; bz = 1'b1; dn = 1'b0; o = 8'h00;
    if (k >= 7 * t) begin
      bz = 1'b0;
      dn = (k == 7 * t);
    end else begin
      case (k / t)
        0: begin s = 4'b0110; oe = 1'b1; o = a; end
        1: begin s = 4'b0010; oe = 1'b1; o = a; end
        2: begin s = 4'b0110; oe = 1'b1; o = a; end
        3: s = 4'b1111;
        4, 6: begin s = 4'b0111; oe = w; o = w ? d : 8'h00; end
        default: begin
          s = w ? 4'b0011 : 4'b0101; oe = w; o = w ? d : 8'h00;
        end
      endcase
    end
    return {s, oe, bz, dn, o};
  endfunction

  function automatic logic [14:0] obs0();
    return {CSO, WRO, RDO, ADO, bus_oe, busy, done, bus_out};
  endfunction

  function automatic logic [14:0] obs1();
    return {CSO1, WRO1, RDO1, ADO1, bus_oe1, busy1, done1, bus_out1};
  endfunction

  task automatic txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input bit perturb);
    int dcnt;
    int clash;
    dcnt = 0;
    clash = 0;
    @(negedge clk);
    start = 1'b1; rw = w; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      check($sformatf("seq w=%0d a=%h k=%0d", w, a, k), 32'(obs0()),
            32'(exp_vec(k, 4, w, a, d)));
      if (done) dcnt++;
      if (bus_oe && !RDO) clash++;
      if (perturb && k == 4) begin
        start = 1'b1; rw = ~w; addr = ~a; wdata = ~d;
      end
      if (perturb && k == 6) start = 1'b0;
      @(negedge clk);
    end
    check($sformatf("done_count a=%h", a), 32'(dcnt), 32'd1);
    check($sformatf("contention a=%h", a), 32'(clash), 32'd0);
    check($sformatf("rdata a=%h", a), 32'(rdata), 32'(exp_rd));
  endtask

  initial begin
    int dcnt;
    int wlow;
    start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00;
    start1 = 1'b0; rw1 = 1'b1; addr1 = 8'h5A; wdata1 = 8'hA5;

    repeat (3) @(negedge clk);
    check("rst_outs", 32'(obs0()), 32'h7800);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_outs1", 32'(obs1()), 32'h7800);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_outs", 32'(obs0()), 32'h7800);
    check("idle_rdata", 32'(rdata), 32'h0);

    txn(1'b1, 8'h21, 8'h45, 8'h00, 1'b0);
    txn(1'b0, 8'h22, 8'h00, 8'h37, 1'b0);
    txn(1'b1, 8'h30, 8'h9C, 8'h37, 1'b1);

    // abort a read in the middle of D_STROBE
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 8'h23;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    check("abort_pre_rdo", 32'(RDO), 32'h0);
    check("abort_pre_rdata", 32'(rdata), 32'h37);
    #2 reset = 1'b0;
    #1;
    check("abort_outs", 32'({CSO, WRO, RDO, ADO, bus_oe, busy, done}),
          32'b1111000);
    check("abort_rdata", 32'(rdata), 32'h0);
    dcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_nodone", 32'(dcnt), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'(obs0()), 32'h7800);
    txn(1'b0, 8'h24, 8'h00, 8'h37, 1'b0);

    // T_PHASE=1 with start held high: period 9 cycles
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    dcnt = 0;
    wlow = 0;
    for (int k = 0; k < 27; k++) begin
      check($sformatf("t1 k=%0d", k), 32'(obs1()),
            32'(exp_vec(k % 9, 1, 1'b1, 8'h5A, 8'hA5)));
      if (done1) dcnt++;
      if (!WRO1) wlow++;
      @(negedge clk);
    end
    start1 = 1'b0;
    check("t1_done_count", 32'(dcnt), 32'd3);
    check("t1_wro_low", 32'(wlow), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
